// File: rtl/sine_period_analyzer_pkg.sv
// Shared definitions for the DDS sine stream analyzer: default stream format,
// measurement FSM states and hysteresis polarity.
package sine_period_analyzer_pkg;

    localparam int DDS_SAMPLE_W = 8;
    localparam int DDS_MIDSCALE = 128;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        POL_NONE = 2'd0,
        POL_LOW  = 2'd1,
        POL_HIGH = 2'd2
    } pol_t;

endpackage

// File: rtl/sine_hyst_cmp.sv
// Hysteresis comparator around mid-scale: holds the LOW/HIGH polarity and
// strobes rise on an accepted sample that moves the polarity from LOW to HIGH.
module sine_hyst_cmp
    import sine_period_analyzer_pkg::*;
#(
    parameter int SAMPLE_W = DDS_SAMPLE_W,
    parameter int MIDSCALE = DDS_MIDSCALE,
    parameter int HYST     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid,
    output logic                is_low,
    output logic                rise
);

    localparam logic [SAMPLE_W-1:0] LOW_TH  = SAMPLE_W'(MIDSCALE - HYST);
    localparam logic [SAMPLE_W-1:0] HIGH_TH = SAMPLE_W'(MIDSCALE + HYST);

    pol_t pol_q;
    logic at_low;
    logic at_high;

    assign at_low  = (sample_i <= LOW_TH);
    assign at_high = (sample_i >= HIGH_TH);
    assign is_low  = sample_valid && at_low;
    assign rise    = sample_valid && at_high && (pol_q == POL_LOW);

    // Between the thresholds the last polarity is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pol_q <= POL_NONE;
        end else if (sample_valid) begin
            if (at_low) begin
                pol_q <= POL_LOW;
            end else if (at_high) begin
                pol_q <= POL_HIGH;
            end
        end
    end

endmodule

// File: rtl/sine_period_analyzer.sv
// Measures period and min/max of a mid-scale-biased sine between rising
// crossings, publishes results on a valid/ready port and flags frequency lock.
module sine_period_analyzer
    import sine_period_analyzer_pkg::*;
#(
    parameter int SAMPLE_W   = DDS_SAMPLE_W,
    parameter int MIDSCALE   = DDS_MIDSCALE,
    parameter int HYST       = 8,
    parameter int PERIOD_W   = 8,
    parameter int MAX_PERIOD = 255,
    parameter int LOCK_COUNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid,
    output logic [PERIOD_W-1:0] period_o,
    output logic [SAMPLE_W-1:0] min_o,
    output logic [SAMPLE_W-1:0] max_o,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                locked,
    output logic                overrun,
    output logic                timeout
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_W-1:0] MAX_CNT   = PERIOD_W'(MAX_PERIOD);
    localparam logic [MATCH_W-1:0]  MATCH_SAT = MATCH_W'(LOCK_COUNT);

    state_t                state_q, state_d;
    logic                  is_low, rise;
    logic                  publish, expire;
    logic [PERIOD_W-1:0]   cnt_q, prev_q;
    logic [SAMPLE_W-1:0]   min_q, max_q;
    logic [MATCH_W-1:0]    match_q;
    logic                  have_prev_q;

    sine_hyst_cmp #(
        .SAMPLE_W (SAMPLE_W),
        .MIDSCALE (MIDSCALE),
        .HYST     (HYST)
    ) u_hyst (
        .clk          (clk),
        .rst          (rst),
        .sample_i     (sample_i),
        .sample_valid (sample_valid),
        .is_low       (is_low),
        .rise         (rise)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        expire  = 1'b0;
        if (en && sample_valid) begin
            case (state_q)
                SEARCH:  if (is_low) state_d = ARMED;
                ARMED:   if (rise) state_d = MEASURE;
                MEASURE: begin
                    if (rise) begin
                        publish = 1'b1;
                    end else if (cnt_q == MAX_CNT) begin
                        expire  = 1'b1;
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // The rise sample opens the next period, so it restarts cnt/min/max
    // rather than joining the period being published.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
        end else if (sample_valid) begin
            if ((state_q == ARMED && rise) || publish) begin
                cnt_q <= PERIOD_W'(1);
                min_q <= sample_i;
                max_q <= sample_i;
            end else if (state_q == MEASURE && !expire) begin
                cnt_q <= cnt_q + PERIOD_W'(1);
                if (sample_i < min_q) min_q <= sample_i;
                if (sample_i > max_q) max_q <= sample_i;
            end
            if (publish) begin
                prev_q      <= cnt_q;
                have_prev_q <= 1'b1;
                if (have_prev_q && cnt_q == prev_q) begin
                    if (match_q != MATCH_SAT) match_q <= match_q + MATCH_W'(1);
                end else begin
                    match_q <= '0;
                end
            end
            if (expire) begin
                cnt_q       <= '0;
                match_q     <= '0;
                have_prev_q <= 1'b0;
            end
        end
    end

    assign locked = (match_q == MATCH_SAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_o     <= '0;
            min_o        <= '0;
            max_o        <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if (publish) begin
                if (result_valid && !result_ready) begin
                    overrun <= 1'b1;
                end else begin
                    period_o     <= cnt_q;
                    min_o        <= min_q;
                    max_o        <= max_q;
                    result_valid <= 1'b1;
                end
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
            if (expire) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sine_period_analyzer.sv
// Self-checking bench: sample-queue reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_sine_period_analyzer;

    localparam int MAXP  = 255;
    localparam int LOCKN = 4;
    localparam int LO_TH = 120;
    localparam int HI_TH = 136;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] sample_i = 8'd0;
    logic       sample_valid = 1'b0;
    logic       result_ready = 1'b1;
    logic [7:0] period_o, min_o, max_o;
    logic       result_valid, locked, overrun, timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] lut15 [15] = '{8'd128, 8'd180, 8'd222, 8'd249, 8'd255, 8'd238, 8'd203, 8'd154,
                               8'd102, 8'd53, 8'd18, 8'd1, 8'd7, 8'd34, 8'd120};
    logic [7:0] lut20 [20] = '{8'd128, 8'd168, 8'd203, 8'd231, 8'd249, 8'd255, 8'd249, 8'd231,
                               8'd203, 8'd168, 8'd128, 8'd88, 8'd53, 8'd25, 8'd7, 8'd1,
                               8'd7, 8'd25, 8'd53, 8'd88};
    int idx15 = 0;
    int idx20 = 0;

    sine_period_analyzer #(
        .SAMPLE_W   (8),
        .MIDSCALE   (128),
        .HYST       (8),
        .PERIOD_W   (8),
        .MAX_PERIOD (255),
        .LOCK_COUNT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_i     (sample_i),
        .sample_valid (sample_valid),
        .period_o     (period_o),
        .min_o        (min_o),
        .max_o        (max_o),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .locked       (locked),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples of the open period are kept in a queue, every
    // published period is appended to a history list.
    int   m_pol = 0;          // 0 unknown, 1 low, 2 high
    bit   m_armed = 0;
    bit   m_meas = 0;
    int   q[$];
    int   hist[$];
    int   m_period = 0, m_min = 0, m_max = 0;
    bit   m_valid = 0, m_over = 0, m_tmo = 0;

    function automatic bit m_locked();
        if (hist.size() < LOCKN + 1) return 1'b0;
        for (int i = 1; i <= LOCKN; i++)
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit pub, lo, hi, rs;
        int s, p, mn, mx;
        pub = 0; p = 0; mn = 0; mx = 0;
        s = int'(sample_i);
        if (rst) begin
            m_pol = 0; m_armed = 0; m_meas = 0;
            q.delete(); hist.delete();
            m_period = 0; m_min = 0; m_max = 0;
            m_valid = 0; m_over = 0; m_tmo = 0;
        end else begin
            lo = (s <= LO_TH);
            hi = (s >= HI_TH);
            rs = hi && (m_pol == 1);
            if (en && sample_valid) begin
                if (m_meas) begin
                    if (rs) begin
                        p = q.size(); mn = 255; mx = 0;
                        foreach (q[i]) begin
                            if (q[i] < mn) mn = q[i];
                            if (q[i] > mx) mx = q[i];
                        end
                        pub = 1;
                        hist.push_back(p);
                        q.delete(); q.push_back(s);
                    end else if (q.size() == MAXP) begin
                        m_tmo = 1; m_meas = 0;
                        q.delete(); hist.delete();
                    end else begin
                        q.push_back(s);
                    end
                end else if (m_armed) begin
                    if (rs) begin
                        m_meas = 1; m_armed = 0;
                        q.delete(); q.push_back(s);
                    end
                end else if (lo) begin
                    m_armed = 1;
                end
            end
            if (!en) begin
                m_armed = 0; m_meas = 0;
                q.delete(); hist.delete();
            end
            if (sample_valid) begin
                if (lo) m_pol = 1;
                else if (hi) m_pol = 2;
            end
            if (pub) begin
                if (m_valid && !result_ready) m_over = 1;
                else begin
                    m_valid = 1; m_period = p; m_min = mn; m_max = mx;
                end
            end else if (result_ready) begin
                m_valid = 0;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("result_valid", result_valid, m_valid);
            chk("period_o", period_o, m_period);
            chk("min_o", min_o, m_min);
            chk("max_o", max_o, m_max);
            chk("locked", locked, m_locked());
            chk("overrun", overrun, m_over);
            chk("timeout", timeout, m_tmo);
        end
    end

    bit         mon_en = 0;
    int         n_res = 0;
    int         lock_at = 0;
    logic [7:0] f_period = 0, f_min = 0, f_max = 0;
    always @(negedge clk) begin
        if (mon_en && result_valid) begin
            n_res++;
            if (n_res == 1) begin
                f_period = period_o; f_min = min_o; f_max = max_o;
            end
            if (locked && lock_at == 0) lock_at = n_res;
        end
    end

    task automatic step(input logic [7:0] s, input bit v);
        @(negedge clk);
        sample_i = s;
        sample_valid = v;
    endtask

    task automatic idle();
        step(sample_i, 1'b0);
    endtask

    // gap_mode: 0 back-to-back, 1 invalid cycle before each sample,
    // 2 random gaps and random backpressure
    task automatic feed15(input int n, input int gap_mode);
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 1) begin
                step(8'd85, 1'b0);
            end else if (gap_mode == 2) begin
                for (int g = $urandom_range(0, 2); g > 0; g--)
                    step(8'($urandom_range(0, 255)), 1'b0);
                result_ready = ($urandom_range(0, 3) != 0);
            end
            step(lut15[idx15], 1'b1);
            idx15 = (idx15 + 1) % 15;
        end
    endtask

    task automatic feed20(input int n);
        for (int k = 0; k < n; k++) begin
            step(lut20[idx20], 1'b1);
            idx20 = (idx20 + 1) % 20;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_valid", result_valid, 0);
        chk("reset_period", period_o, 0);
        chk("reset_locked", locked, 0);
        rst = 1'b0;

        // Continuous 15-sample LUT
        mon_en = 1;
        feed15(15 * 10, 0);
        idle();
        mon_en = 0;
        chk("t1_first_period", f_period, 15);
        chk("t1_first_min", f_min, 1);
        chk("t1_first_max", f_max, 255);
        chk("t1_lock_at_result", lock_at, 5);
        chk("t1_locked", locked, 1);
        chk("t1_overrun", overrun, 0);
        chk("t1_timeout", timeout, 0);

        // Alternating sample_valid
        feed15(15 * 6, 1);
        idle();
        chk("t2_period", period_o, 15);
        chk("t2_locked", locked, 1);

        // Backpressure
        result_ready = 1'b0;
        feed15(40, 0);
        idle();
        chk("t3_held_valid", result_valid, 1);
        chk("t3_held_period", period_o, 15);
        chk("t3_overrun", overrun, 1);
        result_ready = 1'b1;
        feed15(30, 0);
        idle();
        chk("t3_next_period", period_o, 15);

        // Flat mid-scale input
        for (int k = 0; k < 300; k++) step(8'd128, 1'b1);
        idle();
        chk("t4_timeout", timeout, 1);
        chk("t4_locked", locked, 0);
        chk("t4_no_result", result_valid, 0);

        // Frequency change after lock
        while (idx15 != 0) feed15(1, 0);
        feed15(15 * 10, 0);
        idle();
        chk("t5_relocked15", locked, 1);
        idx20 = 0;
        feed20(25);
        idle();
        chk("t5_unlock", locked, 0);
        chk("t5_period20", period_o, 20);
        feed20(85);
        idle();
        chk("t5_relock20", locked, 1);

        // Random gaps, backpressure and a soft clear
        feed15(200, 2);
        result_ready = 1'b1;
        en = 1'b0;
        feed15(3, 0);
        en = 1'b1;
        feed15(150, 2);
        result_ready = 1'b1;
        feed15(40, 0);
        idle();

        // Reset mid-period
        feed15(7, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", result_valid, 0);
        chk("t6_rst_period", period_o, 0);
        chk("t6_rst_min", min_o, 0);
        chk("t6_rst_max", max_o, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_overrun", overrun, 0);
        chk("t6_rst_timeout", timeout, 0);
        rst = 1'b0;
        feed15(10, 0);
        idle();
        chk("t6_no_early_result", result_valid, 0);
        feed15(60, 0);
        idle();
        chk("t6_result_period", period_o, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
